// File: rtl/agc_epcs_pkg.sv
// Shared definitions for the EPCS burst reader: opcode, FSM states and
// phase-length helpers.
package agc_epcs_pkg;

  // SPI-flash READ opcode, sent MSB first at the start of every burst.
  localparam logic [7:0] READ_OP = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDRS,
    DATA,
    DESEL,
    ZDONE
  } state_e;

  // Number of DCLK bits in one unit of the given phase (DATA counts per word).
  function automatic int unsigned phase_bits(state_e s, int unsigned addr_w,
                                             int unsigned word_w);
    case (s)
      CMD:     return 8;
      ADDRS:   return addr_w;
      DATA:    return word_w;
      default: return 0;
    endcase
  endfunction

  // True while chip select is low and DCLK is running.
  function automatic logic shifting(state_e s);
    return s inside {CMD, ADDRS, DATA};
  endfunction

endpackage

// File: rtl/epcs_burst_reader_if.sv
// Request/word-stream side of the EPCS burst reader. The consumer is the
// master; the reader is the slave.
interface epcs_burst_reader_if #(
  parameter int ADDR_W = 24,
  parameter int CNT_W  = 12,
  parameter int WORD_W = 16
);
  logic              REQ;
  logic [ADDR_W-1:0] ADDR;
  logic [CNT_W-1:0]  COUNT;
  logic              ABORT;
  logic              BUSY;
  logic [WORD_W-1:0] WORD_DATA;
  logic              WORD_VALID;
  logic              DONE;

  modport master (
    output REQ, ADDR, COUNT, ABORT,
    input  BUSY, WORD_DATA, WORD_VALID, DONE
  );

  modport slave (
    input  REQ, ADDR, COUNT, ABORT,
    output BUSY, WORD_DATA, WORD_VALID, DONE
  );
endinterface

// File: rtl/epcs_sclk_gen.sv
// DCLK generator. While enabled, DCLK toggles every CLK_DIV cycles starting
// low. rise_stb/fall_stb are registered look-ahead strobes: each is high
// during the cycle whose closing edge raises/lowers DCLK, so the caller can
// act on the very edge that moves DCLK.
module epcs_sclk_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic dclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             dclk_q, dclk_d;
  logic             run_q, run_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Divider: hold reloaded and low while disabled or on the first enabled edge.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    cnt_d  = DIV_MAX;
    dclk_d = 1'b0;
    run_d  = en;
    if (en && run_q) begin
      if (cnt_q == '0) begin
        cnt_d  = DIV_MAX;
        dclk_d = ~dclk_q;
      end else begin
        cnt_d  = cnt_q - 1'b1;
        dclk_d = dclk_q;
      end
    end
    rise_d = en && (cnt_d == '0) && !dclk_d;
    fall_d = en && (cnt_d == '0) && dclk_d;
  end

  // Divider registers with synchronous reset to DCLK low.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      cnt_q  <= DIV_MAX;
      dclk_q <= 1'b0;
      run_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dclk_q <= dclk_d;
      run_q  <= run_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign dclk     = dclk_q;
  assign rise_stb = rise_q;
  assign fall_stb = fall_q;

endmodule

// File: rtl/epcs_burst_reader.sv
// EPCS SPI-flash burst reader: sends READ + address, then shifts in COUNT
// words of WORD_W bits (MSB first) and strobes each one out.
module epcs_burst_reader
  import agc_epcs_pkg::*;
#(
  parameter int WORD_W  = 16,
  parameter int ADDR_W  = 24,
  parameter int CNT_W   = 12,
  parameter int CLK_DIV = 1,
  parameter int CSN_HI  = 4
) (
  input  logic                  SYS_CLK,
  input  logic                  SIM_RST_n,
  epcs_burst_reader_if.slave    rd,
  output logic                  EPCS_CSN,
  output logic                  EPCS_DCLK,
  output logic                  EPCS_ASDI,
  input  logic                  EPCS_DATA
);

  localparam int TX_W     = 8 + ADDR_W;
  localparam int MAX_BITS = (ADDR_W > WORD_W) ? ((ADDR_W > 8) ? ADDR_W : 8)
                                              : ((WORD_W > 8) ? WORD_W : 8);
  localparam int BIT_W    = $clog2(MAX_BITS);
  localparam int DSL_W    = (CSN_HI > 1) ? $clog2(CSN_HI) : 1;

  state_e            state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [DSL_W-1:0]  desel_cnt_q, desel_cnt_d;
  logic [TX_W-1:0]   tx_q, tx_d;
  logic [WORD_W-1:0] rx_q, rx_d;
  logic [WORD_W-1:0] word_data_q, word_data_d;
  logic              word_valid_q, word_valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              aborted_q, aborted_d;
  logic              csn_q, csn_d;
  logic              asdi_q, asdi_d;
  logic              sclk_en, rise_stb, fall_stb;

  assign sclk_en = shifting(state_d);

  epcs_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk      (SYS_CLK),
    .rst_n    (SIM_RST_n),
    .en       (sclk_en),
    .dclk     (EPCS_DCLK),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Next-state, shift registers and output strobes.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    desel_cnt_d  = desel_cnt_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    word_data_d  = word_data_q;
    word_valid_d = 1'b0;
    done_d       = 1'b0;
    aborted_d    = aborted_q;

    unique case (state_q)
      IDLE: begin
        if (rd.REQ) begin
          if (rd.COUNT != '0) begin
            state_d    = CMD;
            tx_d       = {READ_OP, rd.ADDR};
            word_cnt_d = rd.COUNT;
            bit_cnt_d  = BIT_W'(phase_bits(CMD, ADDR_W, WORD_W) - 1);
            aborted_d  = 1'b0;
          end else begin
            state_d = ZDONE;
          end
        end
      end

      CMD, ADDRS, DATA: begin
        // Flash data is captured on the edge that raises DCLK.
        if (rise_stb && state_q == DATA) rx_d = {rx_q[WORD_W-2:0], EPCS_DATA};
        // Each falling edge ends a bit: advance ASDI and the bit counters.
        if (fall_stb) begin
          tx_d = {tx_q[TX_W-2:0], 1'b0};
          if (bit_cnt_q != '0) begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end else begin
            case (state_q)
              CMD: begin
                state_d   = ADDRS;
                bit_cnt_d = BIT_W'(phase_bits(ADDRS, ADDR_W, WORD_W) - 1);
              end
              ADDRS: begin
                state_d   = DATA;
                bit_cnt_d = BIT_W'(phase_bits(DATA, ADDR_W, WORD_W) - 1);
              end
              default: begin
                word_data_d  = rx_q;
                word_valid_d = 1'b1;
                if (word_cnt_q == CNT_W'(1)) begin
                  state_d     = DESEL;
                  desel_cnt_d = DSL_W'(CSN_HI - 1);
                end else begin
                  word_cnt_d = word_cnt_q - 1'b1;
                  bit_cnt_d  = BIT_W'(phase_bits(DATA, ADDR_W, WORD_W) - 1);
                end
              end
            endcase
          end
        end
        // Abort wins over any phase transition but keeps a just-completed word.
        if (rd.ABORT) begin
          state_d     = DESEL;
          desel_cnt_d = DSL_W'(CSN_HI - 1);
          aborted_d   = 1'b1;
        end
      end

      DESEL: begin
        if (desel_cnt_q == '0) begin
          state_d = IDLE;
          done_d  = !aborted_q;
        end else begin
          desel_cnt_d = desel_cnt_q - 1'b1;
        end
      end

      ZDONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end

      default: state_d = IDLE;
    endcase

    if (!shifting(state_d)) tx_d = '0;
    asdi_d = shifting(state_d) ? tx_d[TX_W-1] : 1'b0;
    csn_d  = !shifting(state_d);
    busy_d = (state_d != IDLE) || (state_q == ZDONE);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge SYS_CLK) begin
    if (!SIM_RST_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      desel_cnt_q  <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      aborted_q    <= 1'b0;
      csn_q        <= 1'b1;
      asdi_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      desel_cnt_q  <= desel_cnt_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      aborted_q    <= aborted_d;
      csn_q        <= csn_d;
      asdi_q       <= asdi_d;
    end
  end

  assign rd.BUSY       = busy_q;
  assign rd.WORD_DATA  = word_data_q;
  assign rd.WORD_VALID = word_valid_q;
  assign rd.DONE       = done_q;
  assign EPCS_CSN      = csn_q;
  assign EPCS_ASDI     = asdi_q;

endmodule
